// File: rtl/dsram_like_if.sv
// Data-side SRAM-like bus: request channel from the master, addr_ok/data_ok back from the slave.
interface dsram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/dsram_like_slave.sv
// SRAM-like bus responder: issues each accepted request to a 1-cycle SRAM and returns
// data_ok/rdata in order, RESP_DELAY cycles after the handshake, with bounded outstanding count.
module dsram_like_slave #(
    parameter int ADDR_W     = 10,
    parameter int RESP_DELAY = 2,
    parameter int MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    dsram_like_if.slave       bus,
    input  logic              inhibit,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int OW   = $clog2(MAX_OUTST + 1);
    localparam int LAST = RESP_DELAY - 1;

    logic                  rdy_q, rdy_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [RESP_DELAY-1:0] vld_q, vld_d;
    logic [RESP_DELAY-1:0] wr_q, wr_d;
    logic                  hs;
    logic [31:0]           last_dat;
    logic                  unused_ok;

    // Size is informational and sub-word/high address bits never reach the SRAM.
    assign unused_ok = ^{bus.size, bus.addr[1:0], bus.addr[31:ADDR_W+2]};

    always_comb begin
        rdy_d       = 1'b1;
        bus.addr_ok = rdy_q & ~inhibit & (outst_q < OW'(MAX_OUTST));
        hs          = bus.req & bus.addr_ok;

        ram_en      = hs;
        ram_we      = (hs & bus.wr) ? bus.wstrb : 4'h0;
        ram_addr    = bus.addr[ADDR_W+1:2];
        ram_wdata   = bus.wdata;

        vld_d    = '0;
        wr_d     = '0;
        vld_d[0] = hs;
        wr_d[0]  = bus.wr;
        for (int k = 1; k < RESP_DELAY; k++) begin
            vld_d[k] = vld_q[k-1];
            wr_d[k]  = wr_q[k-1];
        end

        bus.data_ok = vld_q[LAST];
        bus.rdata   = (vld_q[LAST] & ~wr_q[LAST]) ? last_dat : 32'h0;

        outst_d = outst_q;
        case ({hs, bus.data_ok})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q   <= 1'b0;
            outst_q <= '0;
            vld_q   <= '0;
            wr_q    <= '0;
        end else begin
            rdy_q   <= rdy_d;
            outst_q <= outst_d;
            vld_q   <= vld_d;
            wr_q    <= wr_d;
        end
    end

    generate
        if (RESP_DELAY == 1) begin : g_comb_data
            // Response cycle is the SRAM read cycle, so data comes straight through.
            assign last_dat = ram_rdata;
        end else begin : g_pipe_data
            logic [RESP_DELAY-1:1][31:0] dat_q, dat_d;

            always_comb begin
                dat_d    = '0;
                dat_d[1] = (vld_q[0] & ~wr_q[0]) ? ram_rdata : 32'h0;
                for (int k = 2; k < RESP_DELAY; k++) begin
                    dat_d[k] = dat_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    dat_q <= '0;
                end else begin
                    dat_q <= dat_d;
                end
            end

            assign last_dat = dat_q[RESP_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_dsram_like_slave.sv
// Bench for dsram_like_slave: word-level reference memory plus an in-order response queue,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_dsram_like_slave;
    localparam int AW = 10;
    localparam int RD = 2;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          inhibit = 1'b0;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    dsram_like_if bus();

    dsram_like_slave #(.ADDR_W(AW), .RESP_DELAY(RD), .MAX_OUTST(MO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .inhibit   (inhibit),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    logic [31:0]   sram    [0:1023];
    logic [31:0]   ref_mem [0:1023];
    logic          log_dok [0:4095];
    logic [31:0]   log_rd  [0:4095];
    logic [3:0]    log_we  [0:4095];
    logic [AW-1:0] log_ad  [0:4095];

    // Environment SRAM: 1-cycle read latency, byte-lane writes.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) ram_rdata <= sram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int ix(input int c);
        return (c < 0 || c > 4095) ? 0 : c;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] dat;
    } resp_t;
    resp_t q[$];

    logic rdy_m;
    always @(posedge clk or negedge resetn)
        if (!resetn) rdy_m <= 1'b0;
        else         rdy_m <= 1'b1;

    // Model: a request accepted at cycle c answers at c+RD with memory contents as of acceptance.
    always @(negedge clk) begin
        logic        exp_aok, exp_dok, hs_m;
        logic [31:0] exp_rd;
        int          wi;
        if (cyc >= 0 && cyc < 4096) begin
            log_dok[cyc] = bus.data_ok;
            log_rd[cyc]  = bus.rdata;
            log_we[cyc]  = ram_we;
            log_ad[cyc]  = ram_addr;
        end
        if (!resetn) begin
            q.delete();
            chk("rst_addr_ok", {31'h0, bus.addr_ok}, 32'h0);
            chk("rst_data_ok", {31'h0, bus.data_ok}, 32'h0);
            chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
            chk("rst_rdata", bus.rdata, 32'h0);
        end else begin
            exp_aok = rdy_m && !inhibit && (q.size() < MO);
            chk("addr_ok", {31'h0, bus.addr_ok}, {31'h0, exp_aok});
            exp_dok = (q.size() > 0) && (q[0].due == cyc);
            chk("data_ok", {31'h0, bus.data_ok}, {31'h0, exp_dok});
            exp_rd = exp_dok ? q[0].dat : 32'h0;
            chk("rdata", bus.rdata, exp_rd);
            if (exp_dok) void'(q.pop_front());
            hs_m = bus.req && exp_aok;
            chk("ram_en", {31'h0, ram_en}, {31'h0, hs_m});
            if (hs_m) begin
                wi = int'(bus.addr[AW+1:2]);
                chk("ram_addr", {22'h0, ram_addr}, {22'h0, bus.addr[AW+1:2]});
                chk("ram_we", {28'h0, ram_we}, {28'h0, bus.wr ? bus.wstrb : 4'h0});
                if (bus.wr) begin
                    chk("ram_wdata", ram_wdata, bus.wdata);
                    for (int b = 0; b < 4; b++)
                        if (bus.wstrb[b]) ref_mem[wi][8*b +: 8] = bus.wdata[8*b +: 8];
                    q.push_back('{due: cyc + RD, dat: 32'h0});
                end else begin
                    q.push_back('{due: cyc + RD, dat: ref_mem[wi]});
                end
            end else begin
                chk("ram_we_idle", {28'h0, ram_we}, 32'h0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds req until addr_ok; returns the handshake cycle.
    task automatic issue(input logic w, input logic [3:0] st, input logic [31:0] a,
                         input logic [31:0] d, output int hc);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        hc  = -100;
        bus.req = 1'b1; bus.wr = w; bus.wstrb = st; bus.addr = a; bus.wdata = d; bus.size = 2'd2;
        while (!got && n < 40) begin
            @(negedge clk);
            if (bus.addr_ok) begin
                got = 1'b1;
                hc  = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("handshake", {31'h0, got}, 32'h1);
        bus.req = 1'b0;
    endtask

    initial begin
        int t0, t1, t2;
        int h[6];
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.wstrb = 4'h0;
        bus.addr = 32'h0; bus.wdata = 32'h0;

        // Reset held with req asserted, then release.
        idle(3);
        resetn  = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("rel_addr_ok_0", {31'h0, bus.addr_ok}, 32'h0);
        @(negedge clk);
        chk("rel_addr_ok_1", {31'h0, bus.addr_ok}, 32'h1);
        @(posedge clk);
        #1;

        // Write then read of the same word.
        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, t0);
        issue(1'b0, 4'h0, 32'h10, 32'h0, t1);
        idle(5);
        chk("wr_rd_b2b", t1, t0 + 1);
        chk("wr_ram_we", {28'h0, log_we[ix(t0)]}, 32'hF);
        chk("wr_ram_addr", {22'h0, log_ad[ix(t0)]}, 32'h4);
        chk("wr_data_ok", {31'h0, log_dok[ix(t0 + 2)]}, 32'h1);
        chk("wr_rdata", log_rd[ix(t0 + 2)], 32'h0);
        chk("rd_data_ok", {31'h0, log_dok[ix(t0 + 3)]}, 32'h1);
        chk("rd_rdata", log_rd[ix(t0 + 3)], 32'hDEADBEEF);

        // Byte write into the top lane.
        issue(1'b1, 4'hF, 32'h20, 32'h11223344, t0);
        issue(1'b1, 4'h8, 32'h23, 32'h5A5A5A5A, t1);
        issue(1'b0, 4'h0, 32'h20, 32'h0, t2);
        idle(5);
        chk("byte_ram_addr", {22'h0, log_ad[ix(t1)]}, 32'h8);
        chk("byte_rdata", log_rd[ix(t2 + 2)], 32'h5A223344);

        // Continuous requests against the outstanding limit.
        for (int i = 0; i < 6; i++)
            issue(1'b0, 4'h0, (i % 2 == 0) ? 32'h10 : 32'h20, 32'h0, h[i]);
        idle(5);
        chk("lim_gap0", h[1] - h[0], 1);
        chk("lim_gap1", h[2] - h[1], 2);
        chk("lim_gap2", h[3] - h[2], 1);
        chk("lim_gap3", h[4] - h[3], 2);
        chk("lim_gap4", h[5] - h[4], 1);
        for (int i = 0; i < 6; i++)
            chk("lim_order", log_rd[ix(h[i] + 2)], (i % 2 == 0) ? 32'hDEADBEEF : 32'h5A223344);

        // Back-pressure with a response in flight.
        issue(1'b0, 4'h0, 32'h10, 32'h0, t0);
        inhibit = 1'b1;
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inh_addr_ok", {31'h0, bus.addr_ok}, 32'h0);
            chk("inh_ram_en", {31'h0, ram_en}, 32'h0);
            @(posedge clk);
            #1;
        end
        inhibit = 1'b0;
        issue(1'b0, 4'h0, 32'h20, 32'h0, t1);
        idle(4);
        chk("inh_inflight_ok", {31'h0, log_dok[ix(t0 + 2)]}, 32'h1);
        chk("inh_inflight_rd", log_rd[ix(t0 + 2)], 32'hDEADBEEF);
        chk("inh_resume", t1, t0 + 4);
        chk("inh_resume_rd", log_rd[ix(t1 + 2)], 32'h5A223344);

        // Async reset with two reads in flight.
        issue(1'b0, 4'h0, 32'h10, 32'h0, t0);
        issue(1'b0, 4'h0, 32'h20, 32'h0, t1);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(3);
        for (int c = 2; c < 7; c++)
            chk("rst_drop", {31'h0, log_dok[ix(t0 + c)]}, 32'h0);
        issue(1'b0, 4'h0, 32'h10, 32'h0, t0);
        issue(1'b0, 4'h0, 32'h20, 32'h0, t1);
        idle(4);
        chk("rst_outst_clear", t1, t0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
